// File: rtl/multicycle_control_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_fsm_if
// Purpose  : Decode inputs and control outputs exchanged between the
//            multi-cycle control unit and the datapath.
// Revision : 1.0
// ============================================================================
interface multicycle_control_fsm_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       opcode;
    logic             mode;
    logic             zero;
    logic             mem_ready;

    logic             enable_IF;
    logic             enable_ID;
    logic             enable_EX;
    logic             enable_MEM;
    logic             enable_WB;
    logic [1:0]       RAsrc;
    logic             RBsrc;
    logic             regDst;
    logic             regWr;
    logic             ExtOp;
    logic [1:0]       ALUop;
    logic             memRd;
    logic             memWr;
    logic             PCwrite;
    logic [1:0]       PCsrc;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    // Datapath side: supplies decode/status, consumes controls.
    modport master (
        output opcode, mode, zero, mem_ready,
        input  enable_IF, enable_ID, enable_EX, enable_MEM, enable_WB,
        input  RAsrc, RBsrc, regDst, regWr, ExtOp, ALUop,
        input  memRd, memWr, PCwrite, PCsrc, illegal, instr_count
    );

    // Control-unit side.
    modport slave (
        input  opcode, mode, zero, mem_ready,
        output enable_IF, enable_ID, enable_EX, enable_MEM, enable_WB,
        output RAsrc, RBsrc, regDst, regWr, ExtOp, ALUop,
        output memRd, memWr, PCwrite, PCsrc, illegal, instr_count
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_fsm
// Purpose  : IF/ID/EX/MEM/WB sequencer and control decoder for the 16-bit
//            multi-cycle RISC core, with a retired-instruction counter.
// Revision : 1.0
// ============================================================================
module multicycle_control_fsm #(
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    multicycle_control_fsm_if.slave  bus
);
    localparam logic [3:0] c_OP_AND  = 4'h0;
    localparam logic [3:0] c_OP_ADD  = 4'h1;
    localparam logic [3:0] c_OP_SUB  = 4'h2;
    localparam logic [3:0] c_OP_ADDI = 4'h3;
    localparam logic [3:0] c_OP_ANDI = 4'h4;
    localparam logic [3:0] c_OP_LW   = 4'h5;
    localparam logic [3:0] c_OP_SW   = 4'h6;
    localparam logic [3:0] c_OP_BEQ  = 4'h7;
    localparam logic [3:0] c_OP_BNE  = 4'h8;
    localparam logic [3:0] c_OP_JMP  = 4'h9;
    localparam logic [3:0] c_OP_CALL = 4'hA;
    localparam logic [3:0] c_OP_RET  = 4'hB;

    localparam logic [1:0] c_ALU_AND = 2'b00;
    localparam logic [1:0] c_ALU_ADD = 2'b01;
    localparam logic [1:0] c_ALU_SUB = 2'b10;

    localparam logic [1:0] c_PC_NEXT = 2'b00;
    localparam logic [1:0] c_PC_BR   = 2'b01;
    localparam logic [1:0] c_PC_JMP  = 2'b10;
    localparam logic [1:0] c_PC_RET  = 2'b11;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [3:0]       r_op_q;
    logic             r_mode_q;
    logic [CNT_W-1:0] r_count;

    logic [3:0] w_op;
    logic       w_mode;
    logic       w_is_alu, w_is_lw, w_is_sw, w_is_beq, w_is_bne, w_is_br;
    logic       w_is_jmp, w_is_call, w_is_ret, w_is_ill;
    logic       w_taken;

    logic [4:0] w_en;
    logic [1:0] w_rasrc;
    logic       w_rbsrc, w_regdst, w_regwr, w_extop;
    logic [1:0] w_aluop;
    logic       w_memrd, w_memwr, w_pcwrite;
    logic [1:0] w_pcsrc;
    logic       w_illegal;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IF;
            r_op_q   <= 4'hF;
            r_mode_q <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_ID) begin
                r_op_q   <= bus.opcode;
                r_mode_q <= bus.mode;
            end
            if (w_pcwrite) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Decode follows the live opcode only while in ID; later stages use the
    // captured copy so the ID-stage bus may change freely.
    always_comb begin
        w_op      = (r_state == S_ID) ? bus.opcode : r_op_q;
        w_mode    = (r_state == S_ID) ? bus.mode   : r_mode_q;
        w_is_alu  = (w_op <= c_OP_ANDI);
        w_is_lw   = (w_op == c_OP_LW);
        w_is_sw   = (w_op == c_OP_SW);
        w_is_beq  = (w_op == c_OP_BEQ);
        w_is_bne  = (w_op == c_OP_BNE);
        w_is_br   = w_is_beq | w_is_bne;
        w_is_jmp  = (w_op == c_OP_JMP);
        w_is_call = (w_op == c_OP_CALL);
        w_is_ret  = (w_op == c_OP_RET);
        w_is_ill  = (w_op[3:2] == 2'b11);
        w_taken   = (w_is_beq & bus.zero) | (w_is_bne & ~bus.zero);
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IF:  w_next_state = S_ID;
            S_ID:  w_next_state = (w_is_alu | w_is_lw | w_is_sw | w_is_br) ? S_EX : S_IF;
            S_EX: begin
                if (w_is_alu) begin
                    w_next_state = S_WB;
                end else if (w_is_lw | w_is_sw) begin
                    w_next_state = S_MEM;
                end else begin
                    w_next_state = S_IF;
                end
            end
            S_MEM: begin
                if (bus.mem_ready) begin
                    w_next_state = w_is_lw ? S_WB : S_IF;
                end
            end
            S_WB:    w_next_state = S_IF;
            default: w_next_state = S_IF;
        endcase
    end

    always_comb begin
        w_en      = 5'b00000;
        w_rasrc   = 2'b00;
        w_rbsrc   = 1'b0;
        w_regdst  = 1'b0;
        w_regwr   = 1'b0;
        w_extop   = 1'b0;
        w_aluop   = c_ALU_AND;
        w_memrd   = 1'b0;
        w_memwr   = 1'b0;
        w_pcwrite = 1'b0;
        w_pcsrc   = c_PC_NEXT;
        w_illegal = 1'b0;

        if (!reset) begin
            case (r_state)
                S_IF:    w_en = 5'b10000;
                S_ID:    w_en = 5'b01000;
                S_EX:    w_en = 5'b00100;
                S_MEM:   w_en = 5'b00010;
                S_WB:    w_en = 5'b00001;
                default: w_en = 5'b10000;
            endcase

            if (r_state != S_IF) begin
                w_rasrc  = w_is_ret ? 2'b10 : 2'b00;
                w_rbsrc  = w_is_sw | w_is_br;
                w_regdst = w_is_call;
                w_extop  = w_is_lw | w_is_sw |
                           (((w_op == c_OP_ADDI) | (w_op == c_OP_ANDI)) & w_mode);
                if ((w_op == c_OP_ADD) | (w_op == c_OP_ADDI) | w_is_lw | w_is_sw) begin
                    w_aluop = c_ALU_ADD;
                end else if ((w_op == c_OP_SUB) | w_is_br) begin
                    w_aluop = c_ALU_SUB;
                end else begin
                    w_aluop = c_ALU_AND;
                end
            end

            // PCwrite marks the last cycle of every instruction.
            case (r_state)
                S_ID: begin
                    w_regwr   = w_is_call;
                    w_illegal = w_is_ill;
                    if (w_is_jmp | w_is_call | w_is_ret | w_is_ill) begin
                        w_pcwrite = 1'b1;
                        if (w_is_jmp | w_is_call) begin
                            w_pcsrc = c_PC_JMP;
                        end else if (w_is_ret) begin
                            w_pcsrc = c_PC_RET;
                        end
                    end
                end
                S_EX: begin
                    if (w_is_br) begin
                        w_pcwrite = 1'b1;
                        w_pcsrc   = w_taken ? c_PC_BR : c_PC_NEXT;
                    end
                end
                S_MEM: begin
                    w_memrd   = w_is_lw;
                    w_memwr   = w_is_sw;
                    w_pcwrite = w_is_sw & bus.mem_ready;
                end
                S_WB: begin
                    w_regwr   = w_is_alu | w_is_lw;
                    w_pcwrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.enable_IF   = w_en[4];
    assign bus.enable_ID   = w_en[3];
    assign bus.enable_EX   = w_en[2];
    assign bus.enable_MEM  = w_en[1];
    assign bus.enable_WB   = w_en[0];
    assign bus.RAsrc       = w_rasrc;
    assign bus.RBsrc       = w_rbsrc;
    assign bus.regDst      = w_regdst;
    assign bus.regWr       = w_regwr;
    assign bus.ExtOp       = w_extop;
    assign bus.ALUop       = w_aluop;
    assign bus.memRd       = w_memrd;
    assign bus.memWr       = w_memwr;
    assign bus.PCwrite     = w_pcwrite;
    assign bus.PCsrc       = w_pcsrc;
    assign bus.illegal     = w_illegal;
    assign bus.instr_count = reset ? '0 : r_count;
endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control_fsm
// Purpose  : Cycle-by-cycle directed vectors for multicycle_control_fsm, plus
//            a counter-wrap sequence on a narrow-counter instance.
// Revision : 1.0
// ============================================================================
module tb_multicycle_control_fsm;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reset_w = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_fsm_if #(.CNT_W(16)) bus ();
    multicycle_control_fsm_if #(.CNT_W(4))  bus_w ();

    multicycle_control_fsm #(.CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    multicycle_control_fsm #(.CNT_W(4)) dut_w (
        .clk   (clk),
        .reset (reset_w),
        .bus   (bus_w.slave)
    );

    localparam logic [4:0] EIF  = 5'b10000;
    localparam logic [4:0] EID  = 5'b01000;
    localparam logic [4:0] EEX  = 5'b00100;
    localparam logic [4:0] EMEM = 5'b00010;
    localparam logic [4:0] EWB  = 5'b00001;

    typedef struct {
        logic        rst;
        logic [3:0]  op;
        logic        md;
        logic        z;
        logic        mr;
        logic [18:0] ctl;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // {enables IF..WB, RAsrc, RBsrc, regDst, regWr, ExtOp, ALUop, memRd, memWr, PCwrite, PCsrc, illegal}
    logic [18:0] act;
    assign act = {bus.enable_IF, bus.enable_ID, bus.enable_EX, bus.enable_MEM, bus.enable_WB,
                  bus.RAsrc, bus.RBsrc, bus.regDst, bus.regWr, bus.ExtOp, bus.ALUop,
                  bus.memRd, bus.memWr, bus.PCwrite, bus.PCsrc, bus.illegal};

    function automatic logic [18:0] c(logic [4:0] en, logic [1:0] ra, logic rb, logic rd,
                                      logic rw, logic ext, logic [1:0] alu, logic mrd,
                                      logic mwr, logic pw, logic [1:0] ps, logic il);
        return {en, ra, rb, rd, rw, ext, alu, mrd, mwr, pw, ps, il};
    endfunction

    task automatic add(logic rst, logic [3:0] op, logic md, logic z, logic mr,
                       logic [18:0] ctl, logic [15:0] cnt);
        vec_t v;
        v.rst = rst; v.op = op; v.md = md; v.z = z; v.mr = mr; v.ctl = ctl; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("onehot_enables", 32'($countones(act[18:14])), 32'd1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.opcode = 4'h0; bus.mode = 1'b0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        bus_w.opcode = 4'h9; bus_w.mode = 1'b0; bus_w.zero = 1'b0; bus_w.mem_ready = 1'b0;

        // ADD
        add(0, 4'h1, 0, 0, 0, c(EIF, 0,0,0,0,0,0,0,0,0,0,0), 0);
        add(0, 4'h1, 0, 0, 0, c(EID, 0,0,0,0,0,1,0,0,0,0,0), 0);
        add(0, 4'hF, 0, 0, 0, c(EEX, 0,0,0,0,0,1,0,0,0,0,0), 0);
        add(0, 4'hF, 0, 0, 0, c(EWB, 0,0,0,1,0,1,0,0,1,0,0), 0);
        // LW with two wait cycles
        add(0, 4'h5, 0, 0, 0, c(EIF, 0,0,0,0,0,0,0,0,0,0,0), 1);
        add(0, 4'h5, 0, 0, 0, c(EID, 0,0,0,0,1,1,0,0,0,0,0), 1);
        add(0, 4'h5, 0, 0, 1, c(EEX, 0,0,0,0,1,1,0,0,0,0,0), 1);
        add(0, 4'h5, 0, 0, 0, c(EMEM,0,0,0,0,1,1,1,0,0,0,0), 1);
        add(0, 4'h5, 0, 0, 0, c(EMEM,0,0,0,0,1,1,1,0,0,0,0), 1);
        add(0, 4'h5, 0, 0, 1, c(EMEM,0,0,0,0,1,1,1,0,0,0,0), 1);
        add(0, 4'h5, 0, 0, 0, c(EWB, 0,0,0,1,1,1,0,0,1,0,0), 1);
        // BEQ taken
        add(0, 4'h7, 0, 0, 0, c(EIF, 0,0,0,0,0,0,0,0,0,0,0), 2);
        add(0, 4'h7, 0, 0, 0, c(EID, 0,1,0,0,0,2,0,0,0,0,0), 2);
        add(0, 4'h7, 0, 1, 0, c(EEX, 0,1,0,0,0,2,0,0,1,1,0), 2);
        // BNE with zero=1: not taken
        add(0, 4'h8, 0, 0, 0, c(EIF, 0,0,0,0,0,0,0,0,0,0,0), 3);
        add(0, 4'h8, 0, 0, 0, c(EID, 0,1,0,0,0,2,0,0,0,0,0), 3);
        add(0, 4'h8, 0, 1, 0, c(EEX, 0,1,0,0,0,2,0,0,1,0,0), 3);
        // BNE with zero=0: taken
        add(0, 4'h8, 0, 1, 0, c(EIF, 0,0,0,0,0,0,0,0,0,0,0), 4);
        add(0, 4'h8, 0, 1, 0, c(EID, 0,1,0,0,0,2,0,0,0,0,0), 4);
        add(0, 4'h8, 0, 0, 0, c(EEX, 0,1,0,0,0,2,0,0,1,1,0), 4);
        // CALL, RET, illegal
        add(0, 4'hA, 0, 0, 0, c(EIF, 0,0,0,0,0,0,0,0,0,0,0), 5);
        add(0, 4'hA, 0, 0, 0, c(EID, 0,0,1,1,0,0,0,0,1,2,0), 5);
        add(0, 4'hB, 0, 0, 0, c(EIF, 0,0,0,0,0,0,0,0,0,0,0), 6);
        add(0, 4'hB, 0, 0, 0, c(EID, 2,0,0,0,0,0,0,0,1,3,0), 6);
        add(0, 4'hE, 0, 0, 0, c(EIF, 0,0,0,0,0,0,0,0,0,0,0), 7);
        add(0, 4'hE, 0, 0, 1, c(EID, 0,0,0,0,0,0,0,0,1,0,1), 7);
        // ADDI mode=1; mode dropped after ID must not matter
        add(0, 4'h3, 1, 0, 0, c(EIF, 0,0,0,0,0,0,0,0,0,0,0), 8);
        add(0, 4'h3, 1, 0, 0, c(EID, 0,0,0,0,1,1,0,0,0,0,0), 8);
        add(0, 4'h0, 0, 0, 0, c(EEX, 0,0,0,0,1,1,0,0,0,0,0), 8);
        add(0, 4'h0, 0, 0, 0, c(EWB, 0,0,0,1,1,1,0,0,1,0,0), 8);
        // ANDI mode=0
        add(0, 4'h4, 0, 0, 0, c(EIF, 0,0,0,0,0,0,0,0,0,0,0), 9);
        add(0, 4'h4, 0, 0, 0, c(EID, 0,0,0,0,0,0,0,0,0,0,0), 9);
        add(0, 4'h4, 1, 0, 0, c(EEX, 0,0,0,0,0,0,0,0,0,0,0), 9);
        add(0, 4'h4, 1, 0, 0, c(EWB, 0,0,0,1,0,0,0,0,1,0,0), 9);
        // SW with mem_ready already high: single MEM cycle
        add(0, 4'h6, 0, 0, 1, c(EIF, 0,0,0,0,0,0,0,0,0,0,0), 10);
        add(0, 4'h6, 0, 0, 1, c(EID, 0,1,0,0,1,1,0,0,0,0,0), 10);
        add(0, 4'h6, 0, 0, 1, c(EEX, 0,1,0,0,1,1,0,0,0,0,0), 10);
        add(0, 4'h6, 0, 0, 1, c(EMEM,0,1,0,0,1,1,0,1,1,0,0), 10);
        // JMP
        add(0, 4'h9, 0, 0, 0, c(EIF, 0,0,0,0,0,0,0,0,0,0,0), 11);
        add(0, 4'h9, 0, 0, 0, c(EID, 0,0,0,0,0,0,0,0,1,2,0), 11);
        // SUB
        add(0, 4'h2, 0, 0, 0, c(EIF, 0,0,0,0,0,0,0,0,0,0,0), 12);
        add(0, 4'h2, 0, 0, 0, c(EID, 0,0,0,0,0,2,0,0,0,0,0), 12);
        add(0, 4'h2, 0, 0, 0, c(EEX, 0,0,0,0,0,2,0,0,0,0,0), 12);
        add(0, 4'h2, 0, 0, 0, c(EWB, 0,0,0,1,0,2,0,0,1,0,0), 12);
        // SW aborted by reset in the second MEM cycle
        add(0, 4'h6, 0, 0, 0, c(EIF, 0,0,0,0,0,0,0,0,0,0,0), 13);
        add(0, 4'h6, 0, 0, 0, c(EID, 0,1,0,0,1,1,0,0,0,0,0), 13);
        add(0, 4'h6, 0, 0, 0, c(EEX, 0,1,0,0,1,1,0,0,0,0,0), 13);
        add(0, 4'h6, 0, 0, 0, c(EMEM,0,1,0,0,1,1,0,1,0,0,0), 13);
        add(1, 4'h6, 0, 0, 0, 19'd0, 0);
        add(0, 4'h9, 0, 0, 0, c(EIF, 0,0,0,0,0,0,0,0,0,0,0), 0);
        add(0, 4'h9, 0, 0, 0, c(EID, 0,0,0,0,0,0,0,0,1,2,0), 0);
        // AND after recovery
        add(0, 4'h0, 0, 0, 0, c(EIF, 0,0,0,0,0,0,0,0,0,0,0), 1);
        add(0, 4'h0, 0, 0, 0, c(EID, 0,0,0,0,0,0,0,0,0,0,0), 1);
        add(0, 4'h0, 0, 0, 0, c(EEX, 0,0,0,0,0,0,0,0,0,0,0), 1);
        add(0, 4'h0, 0, 0, 0, c(EWB, 0,0,0,1,0,0,0,0,1,0,0), 1);
        add(0, 4'h0, 0, 0, 0, c(EIF, 0,0,0,0,0,0,0,0,0,0,0), 2);

        // Reset held: outputs masked to zero
        repeat (2) begin
            @(negedge clk);
            #1;
            check("reset_ctl", 32'(act), 32'd0);
            check("reset_cnt", 32'(bus.instr_count), 32'd0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset         = vecs[i].rst;
            bus.opcode    = vecs[i].op;
            bus.mode      = vecs[i].md;
            bus.zero      = vecs[i].z;
            bus.mem_ready = vecs[i].mr;
            #1;
            check($sformatf("vec%0d_ctl", i), 32'(act), 32'(vecs[i].ctl));
            check($sformatf("vec%0d_cnt", i), 32'(bus.instr_count), 32'(vecs[i].cnt));
        end

        // Counter wrap on a 4-bit instance: 15 JMPs then an ADD
        @(negedge clk);
        reset_w = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        check("wrap_pre_cnt", 32'(bus_w.instr_count), 32'd15);
        check("wrap_pre_if", 32'(bus_w.enable_IF), 32'd1);
        bus_w.opcode = 4'h1;
        repeat (3) @(negedge clk);
        #1;
        check("wrap_wb_pcwrite", 32'(bus_w.PCwrite), 32'd1);
        check("wrap_wb_cnt", 32'(bus_w.instr_count), 32'd15);
        @(negedge clk);
        #1;
        check("wrap_post_cnt", 32'(bus_w.instr_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main control unit of the multi-cycle 16-bit RISC core. It sequences every instruction through the IF, ID, EX, MEM and WB states and asserts one stage enable at a time (enable_ID drives the ID stage). It also generates the ID-stage operand selects (RAsrc, RBsrc, regDst, ExtOp), the ALU, memory and PC controls, and a retired-instruction counter. It sits beside the datapath, takes opcode and mode from the ID stage, and takes zero and mem_ready from EX and MEM.

## Interface
- Parameters
- CNT_W, 16, width of instr_count
- Ports
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  one clock; reset is synchronous and active-high
- opcode  in  4  opcode from ID stage (valid during ID)
- mode  in  1  mode bit from ID stage (valid during ID)
- zero  in  1  ALU zero flag (valid during EX)
- mem_ready  in  1  data memory completion
- enable_IF, enable_ID, enable_EX, enable_MEM, enable_WB  out  1 each  stage enables, one-hot
- RAsrc  out  2  BusA source: 00 Rs, 01 Rd, 10 R7
- RBsrc  out  1  BusB source: 0 Rt, 1 Rd
- regDst  out  1  write register: 0 Rd, 1 R7
- regWr  out  1  register file write
- ExtOp  out  1  1 = sign-extend Imm16
- ALUop  out  2  00 AND, 01 ADD, 10 SUB
- memRd, memWr  out  1 each  data memory strobes
- PCwrite  out  1  PC update strobe
- PCsrc  out  2  00 nextPC, 01 BTarget, 10 jumpTarget, 11 BusA (return)
- illegal  out  1  one-cycle pulse on undefined opcode
- instr_count  out  CNT_W  retired instructions

## Operation
- Opcode map:
  - 0000 AND, 0001 ADD, 0010 SUB: R-type.
  - 0011 ADDI, 0100 ANDI: I-type; ExtOp = mode.
  - 0101 LW, 0110 SW, 0111 BEQ, 1000 BNE, 1001 JMP, 1010 CALL, 1011 RET.
  - 1100–1111 illegal.
- States IF, ID, EX, MEM, WB; the stage enable equals the current state.
- Transitions by class:
  - IF→ID always.
  - ALU ops: ID→EX→WB→IF.
  - LW: ID→EX→MEM→WB→IF.
  - SW: ID→EX→MEM→IF.
  - BEQ/BNE: ID→EX→IF.
  - JMP/CALL/RET/illegal: ID→IF.
- MEM holds while mem_ready=0; memRd/memWr stay asserted for the whole MEM residency.
- op_q/mode_q capture opcode/mode on the ID→next edge.
- Control outputs decode from the live opcode in ID and from op_q in EX/MEM/WB; outside those states they are 0.
- Operand selects:
  - RAsrc=00 except RET (10).
  - RBsrc=1 for SW, BEQ, BNE.
  - ExtOp=1 for LW, SW; ExtOp=mode for ADDI/ANDI.
- ALUop: ADD for ADD/ADDI/LW/SW; SUB for SUB/BEQ/BNE; AND for AND/ANDI.
- regWr: in WB for ALU ops and LW (regDst=0); in ID for CALL (regDst=1, writes nextPC to R7).
- PCwrite is asserted only in the final state of each instruction, and in MEM only when mem_ready=1. PCsrc in that cycle:
  - 00 for sequential instructions.
  - In EX: 01 if BEQ&zero or BNE&!zero, else 00.
  - 10 for JMP and CALL.
  - 11 for RET.
  - 00 for illegal.
- illegal=1 during ID for an undefined opcode; no register or memory write.
- instr_count increments on every PCwrite cycle, including illegal; it wraps 0xFFFF→0x0000.

## Timing
- While reset=1: all outputs 0 (masked combinationally). At the edge, state←IF, op_q←1111, mode_q←0, instr_count←0.
- The first cycle after reset deassertion is IF with enable_IF=1.
- Reset asserted in any state, including MEM with memRd/memWr high, aborts the instruction. No PCwrite or regWr is issued in that cycle.
- Latency in cycles:
  - ALU 4; LW 5+w; SW 4+w (w = wait cycles with mem_ready=0); branch 3; JMP/CALL/RET/illegal 2.
- Exactly one enable_* high per non-reset cycle; never zero, never two.
- mem_ready is ignored outside MEM; mem_ready=1 on MEM entry gives a single MEM cycle.
- zero is sampled only in EX of BEQ/BNE.
- opcode changes outside ID have no effect.

## Test plan
- Reset, then ADD (0001): enables IF,ID,EX,WB on cycles 1–4. regWr=1 and PCwrite=1 with PCsrc=00 in WB. instr_count=1.
- LW (0101) with mem_ready low 2 cycles: 3 MEM cycles with memRd held, then WB with regWr=1. Total 7 cycles; ExtOp=1, ALUop=01.
- BEQ with zero=1 → PCsrc=01 in EX (3 cycles). BNE with zero=1 → PCsrc=00 in EX.
- CALL then RET:
  - CALL, in ID: regWr=1, regDst=1, PCwrite=1, PCsrc=10.
  - RET, in ID: RAsrc=10, PCsrc=11.
  - instr_count=2.
- opcode 1110: illegal pulse in ID, PCwrite with PCsrc=00, no regWr/memWr, back to IF after 2 cycles.
- SW with mem_ready=0, reset asserted in the 2nd MEM cycle: all outputs 0, no PCwrite. Next cycle is IF, instr_count=0.
- Preload 0xFFFF retirements, then one NOP-class ADD → instr_count wraps to 0x0000.
